// File: rtl/sr_latch_ctrl.sv
// Round-robin controller driving timed active-low set/reset pulses into one shared NAND SR latch.
// Optional macro SR_LATCH_CTRL_SKIP_EN: skip the pulse when the latch already holds the commanded value.
module sr_latch_ctrl #(
  parameter int NREQ    = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] cmd,
  input  logic            q,
  output logic            s_n,
  output logic            r_n,
  output logic [NREQ-1:0] grant,
  output logic            done,
  output logic            mismatch,
  output logic            busy
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   ptr, ptr_d;
  logic [IW-1:0]   win, win_d;
  logic [IW-1:0]   pick;
  logic [IW:0]     scan;
  logic            found;
  logic            op, op_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [NREQ-1:0] grant_d;
  logic            s_n_d, r_n_d;
  logic            q_meta, q_sync;

  // Round-robin scan: first asserted request at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = {1'b0, ptr} + (IW+1)'(i);
      if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
      if (!found && req[scan[IW-1:0]]) begin
        found = 1'b1;
        pick  = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    win_d   = win;
    op_d    = op;
    cnt_d   = cnt;
    grant_d = grant;
    case (state)
      IDLE: begin
        if (found) begin
          grant_d = NREQ'(1) << pick;
          win_d   = pick;
          op_d    = cmd[pick];
          cnt_d   = '0;
`ifdef SR_LATCH_CTRL_SKIP_EN
          state_d = (q_sync == cmd[pick]) ? CHECK : PULSE;
`else
          state_d = PULSE;
`endif
        end
      end
      PULSE: begin
        if (cnt == CW'(PULSE_W - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_W - 1)) state_d = CHECK;
        else                       cnt_d = cnt + CW'(1);
      end
      CHECK: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Latch drives derive from the next state so that only one of them can ever be low.
    s_n_d = ~((state_d == PULSE) &  op_d);
    r_n_d = ~((state_d == PULSE) & ~op_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      op     <= 1'b0;
      cnt    <= '0;
      grant  <= '0;
      s_n    <= 1'b1;
      r_n    <= 1'b1;
      q_meta <= 1'b0;
      q_sync <= 1'b0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      win    <= win_d;
      op     <= op_d;
      cnt    <= cnt_d;
      grant  <= grant_d;
      s_n    <= s_n_d;
      r_n    <= r_n_d;
      q_meta <= q;
      q_sync <= q_meta;
    end
  end

  assign done     = (state == CHECK);
  assign mismatch = done & (q_sync != op);
  assign busy     = (state != IDLE);

endmodule
